// File: rtl/i2c_master_param_if.sv
// Request/response bundle between a transaction requester and the i2c_master_param engine.
// The master modport issues requests; the slave modport is the engine side.
interface i2c_master_param_if #(
  parameter int ADDR_W     = 7,
  parameter int DATA_BYTES = 2,
  parameter int LEN_W      = 2
);
  logic                    start;
  logic                    rd_wr;
  logic [ADDR_W-1:0]       addr;
  logic [LEN_W-1:0]        len;
  logic [8*DATA_BYTES-1:0] wdata;
  logic [8*DATA_BYTES-1:0] rdata;
  logic                    busy;
  logic                    done;
  logic                    ack_err;

  modport master (output start, rd_wr, addr, len, wdata,
                  input  rdata, busy, done, ack_err);
  modport slave  (input  start, rd_wr, addr, len, wdata,
                  output rdata, busy, done, ack_err);
endinterface

// File: rtl/i2c_master_param.sv
// Single-clock I2C master with internal SCL quarter-tick divider and multi-byte bursts.
// Optional macro I2C_CLK_STRETCH_EN: freeze the quarter counter while a slave holds SCL low.
module i2c_master_param #(
  parameter int ADDR_W     = 7,
  parameter int DATA_BYTES = 2,
  parameter int CLK_DIV    = 250,
  parameter int LEN_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  i2c_master_param_if.slave bus,
  inout  wire              sda,
  inout  wire              scl
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int DW    = 8*DATA_BYTES;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WBYTE, S_WACK, S_RBYTE, S_MACK, S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       q_q;
  logic [2:0]       bit_cnt_q;
  logic [LEN_W-1:0] len_q, byte_cnt_q;
  logic             rd_wr_q;
  logic [7:0]       tx_q, rx_q;
  logic [DW-1:0]    wsh_q, rdata_q;
  logic             smp_q, done_q, ack_err_q;
  logic             scl_low, sda_low, freeze, tick, samp, bit_end, last_byte;

  // Open-drain pads: only ever pull low or let go.
  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
  assign freeze = (state_q != S_IDLE) && !scl_low && !scl;
`else
  assign freeze = 1'b0;
`endif

  assign tick      = (cnt_q == CNT_W'(CLK_DIV-1)) && !freeze;
  assign samp      = tick && (q_q == 2'd2);
  assign bit_end   = tick && (q_q == 2'd3);
  assign last_byte = (byte_cnt_q == len_q - 1'b1);

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.ack_err = ack_err_q;
  assign bus.rdata   = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    scl_low = 1'b0;
    sda_low = 1'b0;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_START;
      S_START: begin
        // SDA falls in Q2 with SCL still high, SCL follows in Q3.
        sda_low = (q_q >= 2'd2);
        scl_low = (q_q == 2'd3);
        if (bit_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        scl_low = (q_q < 2'd2);
        sda_low = !tx_q[7];
        if (bit_end && bit_cnt_q == 3'd7) state_d = S_AACK;
      end
      S_AACK: begin
        scl_low = (q_q < 2'd2);
        if (bit_end) state_d = smp_q ? S_STOP : (rd_wr_q ? S_RBYTE : S_WBYTE);
      end
      S_WBYTE: begin
        scl_low = (q_q < 2'd2);
        sda_low = !tx_q[7];
        if (bit_end && bit_cnt_q == 3'd7) state_d = S_WACK;
      end
      S_WACK: begin
        scl_low = (q_q < 2'd2);
        if (bit_end) state_d = (smp_q || last_byte) ? S_STOP : S_WBYTE;
      end
      S_RBYTE: begin
        scl_low = (q_q < 2'd2);
        if (bit_end && bit_cnt_q == 3'd7) state_d = S_MACK;
      end
      S_MACK: begin
        scl_low = (q_q < 2'd2);
        sda_low = !last_byte;
        if (bit_end) state_d = last_byte ? S_STOP : S_RBYTE;
      end
      S_STOP: begin
        scl_low = (q_q < 2'd2);
        sda_low = (q_q != 2'd3);
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      q_q        <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      rd_wr_q    <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      wsh_q      <= '0;
      rdata_q    <= '0;
      smp_q      <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        cnt_q      <= '0;
        q_q        <= '0;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        if (bus.start) begin
          rd_wr_q   <= bus.rd_wr;
          tx_q      <= 8'({bus.addr, bus.rd_wr});
          wsh_q     <= bus.wdata;
          ack_err_q <= 1'b0;
          if (bus.len == '0)                   len_q <= LEN_W'(1);
          else if (int'(bus.len) > DATA_BYTES) len_q <= LEN_W'(DATA_BYTES);
          else                                 len_q <= bus.len;
        end
      end else begin
        if (!freeze) cnt_q <= tick ? '0 : cnt_q + 1'b1;
        if (tick)    q_q   <= q_q + 1'b1;
        if (samp) begin
          smp_q <= sda;
          if (state_q == S_RBYTE) rx_q <= {rx_q[6:0], sda};
        end
        if (bit_end) begin
          unique case (state_q)
            S_ADDR, S_WBYTE: begin
              tx_q      <= {tx_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            S_RBYTE: begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 3'd7)
                rdata_q[8*(DATA_BYTES-1-int'(byte_cnt_q)) +: 8] <= rx_q;
            end
            S_AACK, S_WACK: if (smp_q) ack_err_q <= 1'b1;
            S_STOP:         done_q <= 1'b1;
            default: ;
          endcase
          if ((state_q == S_WACK || state_q == S_MACK) && state_d != S_STOP)
            byte_cnt_q <= byte_cnt_q + 1'b1;
          // Next write byte is pulled off the top of the latched burst.
          if (state_d == S_WBYTE && state_q != S_WBYTE) begin
            tx_q  <= wsh_q[DW-1 -: 8];
            wsh_q <= wsh_q << 8;
          end
        end
      end
    end
  end
endmodule
